// File: rtl/imem_loader_pkg.sv
// Types for the instruction-memory loader; state encodings come from mips_defs.vh.
// Latency: n/a (types only).
// Backpressure: n/a.
package imem_loader_pkg;

`include "mips_defs.vh"

  typedef enum logic [2:0] {
    S_IDLE   = `LDR_ST_IDLE,
    S_HDR_HI = `LDR_ST_HDR_HI,
    S_HDR_LO = `LDR_ST_HDR_LO,
    S_DATA   = `LDR_ST_DATA,
    S_CSUM   = `LDR_ST_CSUM,
    S_DONE   = `LDR_ST_DONE,
    S_ERROR  = `LDR_ST_ERROR
  } ldr_state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Packs accepted bytes big-endian into 32-bit words (first byte -> [31:24]).
// Latency: combinational; word_valid/word present in the same cycle as the 4th byte.
// Backpressure: none; consumes every byte_fire.
// Ports: clk, reset (async, active-high), clear (restart at byte 0),
//        byte_fire/byte_data (accepted byte), word_valid/word (completed word).
module loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      cnt   <= '0;
    end else if (byte_fire) begin
      shreg <= {shreg[15:0], byte_data};
      cnt   <= cnt + 2'd1;
    end
  end

  // The 4th byte completes the word without being stored.
  assign word_valid = byte_fire && (cnt == 2'd3);
  assign word       = {shreg, byte_data};

endmodule

// File: rtl/mips_defs.vh
// Shared loader constants: loader FSM state encodings and the stream header length.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef MIPS_DEFS_VH
`define MIPS_DEFS_VH

// Header is a 16-bit big-endian word count.
`define LDR_HDR_LEN   2

`define LDR_ST_IDLE   3'd0
`define LDR_ST_HDR_HI 3'd1
`define LDR_ST_HDR_LO 3'd2
`define LDR_ST_DATA   3'd3
`define LDR_ST_CSUM   3'd4
`define LDR_ST_DONE   3'd5
`define LDR_ST_ERROR  3'd6

`endif

// File: rtl/imem_loader.sv
// Loads a byte stream (16-bit word count N, then N big-endian words) into instruction memory
// from word 0 and holds the core in reset until a load succeeds.
// Latency: 4th byte accepted -> imem_we next cycle; final write -> done one cycle later.
// Backpressure: rx_ready only in header/data/checksum states; never throttles within a load.
// Ports: clk, reset (async, active-high), start, rx_data/rx_valid/rx_ready,
//        imem_we/imem_addr/imem_wdata, cpu_hold, busy, done, error, words_loaded.
// Option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR-of-data-bytes checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  ldr_state_t      state;
  logic [15:0]     nwords;
  logic            fire;
  logic            data_fire;
  logic            start_ok;
  logic            word_valid;
  logic [31:0]     word;
  logic [15:0]     hdr_n;
  logic [ADDR_W:0] wl_nxt;
  logic            last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`else
  // One-cycle gap between the final write and done.
  logic            fin;
`endif

  assign fire      = rx_valid && rx_ready;
  assign data_fire = fire && (state == S_DATA);
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign hdr_n     = {nwords[15:8], rx_data};
  assign wl_nxt    = words_loaded + (ADDR_W+1)'(1);
  assign last_word = (16'(wl_nxt) == nwords);

  loader_word_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_fire  (data_fire),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      nwords       <= '0;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`else
      fin          <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_ok) begin
            state        <= S_HDR_HI;
            rx_ready     <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end

        S_HDR_HI: begin
          if (fire) begin
            nwords[15:8] <= rx_data;
            state        <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (fire) begin
            nwords[7:0] <= rx_data;
            if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              // Empty programs still carry a (zero) checksum byte.
              state    <= S_CSUM;
`else
              state    <= S_DONE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else if (hdr_n > 16'(DEPTH)) begin
              state    <= S_ERROR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (data_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (word_valid) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= word;
              words_loaded <= wl_nxt;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= S_CSUM;
`else
                rx_ready <= 1'b0;
                fin      <= 1'b1;
`endif
              end
            end
          end
`ifndef IMEM_LOADER_CHECKSUM_EN
          if (fin) begin
            fin      <= 1'b0;
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
`endif
        end

        S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (fire) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERROR;
              error    <= 1'b1;
            end
          end
`else
          // Unreachable without the checksum option.
          state <= S_IDLE;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a stream-level reference model.
// Latency: checks write strobe 1 cycle after the 4th byte and done 1 cycle after the last write.
// Backpressure: drives bytes with random or zero gaps; expects no stalls within a load.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  int waits   = 0;

  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_wl;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) got_q.push_back({imem_addr, imem_wdata});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: reads the stream as "count, words, optional checksum".
  function automatic void model(input bq_t s);
    int n;
    logic [7:0] x;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_wl   = 0;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      logic [7:0] a;
      a = 8'(k);
      exp_q.push_back({a, s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]});
      for (int j = 0; j < 4; j++) x = x ^ s[2+4*k+j];
    end
    exp_wl = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (s[2+4*n] == x) exp_done = 1'b1;
    else               exp_err  = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endfunction

  function automatic bq_t build(input int n, input bit corrupt);
    bq_t s;
    logic [7:0] x;
    logic [7:0] b;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n & 255));
    x = 8'h00;
    if (n <= DEPTH) begin
      for (int i = 0; i < 4*n; i++) begin
        b = 8'($urandom_range(255));
        x = x ^ b;
        s.push_back(b);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(corrupt ? (x ^ 8'h01) : x);
`endif
    end
    return s;
  endfunction

  task automatic nedge_idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin
      waits++;
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  task automatic run_load(input bq_t s, input int maxgap, input int mid);
    got_q.delete();
    model(s);
    pulse_start();
    for (int i = 0; i < s.size(); i++) begin
      if (i == mid) begin
        pulse_start();
        check("busy_after_ignored_start", {63'd0, busy}, 64'd1);
      end
      send_byte(s[i], $urandom_range(maxgap));
    end
    nedge_idle();
    repeat (2) @(negedge clk);
    check("we_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("we_addr_data", {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    check("done", {63'd0, done}, {63'd0, exp_done});
    check("error", {63'd0, error}, {63'd0, exp_err});
    check("cpu_hold", {63'd0, cpu_hold}, {63'd0, ~exp_done});
    check("busy_end", {63'd0, busy}, 64'd0);
    check("rx_ready_end", {63'd0, rx_ready}, 64'd0);
    check("words_loaded", 64'(words_loaded), 64'(exp_wl));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
    check({tag, "_imem_we"}, {63'd0, imem_we}, 64'd0);
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    bq_t s;
    // Power-on reset.
    @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // T1: reset mid-word after 2 of 4 data bytes.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_outputs("t1_in_reset");
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    repeat (10) @(negedge clk);
    check("t1_no_write_after_reset", 64'(got_q.size()), 64'd0);
    check_reset_outputs("t1_after");

    // T2: basic two-word load with latency checks.
    got_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    nedge_idle();
    check("t2_we0", {63'd0, imem_we}, 64'd1);
    check("t2_addr0", 64'(imem_addr), 64'd0);
    check("t2_data0", 64'(imem_wdata), 64'h20080005);
    check("t2_wl1", 64'(words_loaded), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    nedge_idle();
    check("t2_we1", {63'd0, imem_we}, 64'd1);
    check("t2_addr1", 64'(imem_addr), 64'd1);
    check("t2_data1", 64'(imem_wdata), 64'h0);
    check("t2_done_not_yet", {63'd0, done}, 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2D, 0);
`endif
    nedge_idle();
    check("t2_done", {63'd0, done}, 64'd1);
    check("t2_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    check("t2_wl2", 64'(words_loaded), 64'd2);
    check("t2_we_count", 64'(got_q.size()), 64'd2);

    // T5b: start in DONE clears status on the next cycle.
    pulse_start();
    check("t5_done_cleared", {63'd0, done}, 64'd0);
    check("t5_cpu_hold_set", {63'd0, cpu_hold}, 64'd1);
    check("t5_wl_cleared", 64'(words_loaded), 64'd0);
    do_reset();

    // T4: N=0 completes right after the header (plus zero checksum if enabled).
    got_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    nedge_idle();
    check("t4_n0_done", {63'd0, done}, 64'd1);
    check("t4_n0_cpu_hold", {63'd0, cpu_hold}, 64'd0);

    // T4: N=257 exceeds DEPTH.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    nedge_idle();
    check("t4_n257_error", {63'd0, error}, 64'd1);
    check("t4_n257_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    repeat (4) @(negedge clk);
    check("t4_no_writes", 64'(got_q.size()), 64'd0);

    // T5a: start during DATA is ignored.
    s = build(3, 1'b0);
    run_load(s, 1, 6);

    // T3: continuous valid, no stalls, one write per 4 bytes.
    waits = 0;
    s = build(int'($urandom_range(1, 8)), 1'b0);
    run_load(s, 0, -1);
    check("t3_no_stall", 64'(waits), 64'd0);

    // Full-depth boundary.
    s = build(DEPTH, 1'b0);
    run_load(s, 0, -1);

    // Oversized count via the model.
    s = build(257 + int'($urandom_range(0, 1000)), 1'b0);
    run_load(s, 0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // T6: the T2 stream with good and bad checksums.
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    run_load(s, 0, -1);
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2C};
    run_load(s, 0, -1);
`endif

    // Randomized loads with random gaps.
    for (int r = 0; r < 10; r++) begin
      s = build(int'($urandom_range(0, 6)), ($urandom_range(3) == 0));
      run_load(s, 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
